wb_host_master: RTL and testbench
=================================

# wb_host_master

Wishbone classic single-transfer master: the initiating end of the 32-bit Wishbone slave port that the SHA-3 core exposes on `wbs_*` in the user project. It accepts read/write commands on a valid/ready command channel and runs one Wishbone cycle per command. It returns read data or a timeout error on a valid/ready response channel. It is used as the bus driver in block-level benches and as the on-chip host for self-test sequencing of the hash core.

## Interface
- `TIMEOUT_CYCLES`, default 255: number of cycles `stb` may stay high without `ack` before the transfer is aborted; legal range 1..65535.
- `wb_clk_i` in 1: the only clock; everything is sampled on its rising edge.
- `wb_rst_i` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when high together with `cmd_valid`.
- `cmd_we` in 1: 1 = write, 0 = read.
- `cmd_adr` in 32: byte address.
- `cmd_dat` in 32: write data; ignored for reads.
- `cmd_sel` in 4: byte lane selects.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed when high together with `rsp_valid`.
- `rsp_dat` out 32: read data; 0 for writes and on error.
- `rsp_err` out 1: transfer timed out.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o` out 1 each: Wishbone cycle, strobe and write enable.
- `wbm_adr_o` out 32, `wbm_dat_o` out 32, `wbm_sel_o` out 4: Wishbone address, write data and byte selects.
- `wbm_ack_i` in 1: slave acknowledge.
- `wbm_dat_i` in 32: slave read data.

## Operation
- FSM states: IDLE, BUS, RESP. Reset enters IDLE.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`: register `we/adr/dat/sel`, clear the timeout counter, go to BUS.
- **BUS**
  - `wbm_cyc_o`=`wbm_stb_o`=1.
  - `wbm_we_o/adr/dat/sel` are driven from the registered command and held stable for the whole cycle.
  - `cmd_ready`=0.
  - On `wbm_ack_i`=1:
    - For a read, capture `rsp_dat`=`wbm_dat_i`; for a write, `rsp_dat`=0.
    - `rsp_err`=0; go to RESP.
  - Otherwise the counter increments. When the counter equals `TIMEOUT_CYCLES-1` with no ack: `rsp_err`=1, `rsp_dat`=0, go to RESP.
  - If ack and timeout fall in the same cycle, ack wins and `rsp_err`=0.
- **RESP**
  - `rsp_valid`=1; `cyc`/`stb` low; `rsp_dat`/`rsp_err` held stable.
  - On `rsp_ready`: go to IDLE.
- An ack received while `cyc` is low (for example a late ack after a timeout) is ignored and has no effect.
- At most one outstanding transfer; no pipelining, no burst (CTI/BTE not driven).
- Counter width is `$clog2(TIMEOUT_CYCLES+1)`. It saturates and never wraps.
- **Reset values**
  - All outputs 0, except `cmd_ready`=1 from the first cycle after reset.
  - `wbm_adr_o/dat_o/sel_o/we_o` = 0.
- Reset asserted during BUS or RESP: the next edge forces IDLE and drops `cyc`/`stb`. The pending response is discarded.

## Timing
- Command handshake at edge N → `cyc`/`stb` high from cycle N+1.
- Ack sampled at edge M → `cyc`/`stb` low and `rsp_valid` high from cycle M+1.
- Zero-wait slave (ack in the first BUS cycle): `cmd` accept to `rsp_valid` is 2 cycles.
- Response handshake at edge R → `cmd_ready` high at R+1. Back-to-back transfers therefore have minimum spacing of 3 cycles, with `cyc` low for at least 2 cycles between them.
- Timeout: `stb` is high for exactly `TIMEOUT_CYCLES` cycles, then `rsp_valid` with `rsp_err`=1.
- All outputs come from registers; there is no combinational path from `wbm_ack_i` to any output.

## Structure
- Package `wb_pkg` holds:
  - the `wb_state_e` enum (IDLE, BUS, RESP);
  - `WB_AW`=32, `WB_DW`=32, `WB_SELW`=4;
  - the `wb_cmd_t` struct (`we`, `adr`, `dat`, `sel`) shared with benches.
- One sub-module, `wb_timeout_counter`:
  - inputs: clear, enable;
  - output: `expired` at `TIMEOUT_CYCLES-1`;
  - saturating.
- Everything else lives in one `always_ff` FSM with registered outputs.

## Test plan
- Write `adr`=0x3000_0004, `dat`=0xDEAD_BEEF, `sel`=0xF, slave acks in the first cycle:
  - `wbm_*` carries those values with `we`=1 for exactly 1 cycle;
  - `rsp_valid` with `err`=0, `rsp_dat`=0, two cycles after accept.
- Read `adr`=0x3000_0010, slave acks after 3 wait cycles with 0x1234_5678:
  - `stb` high 4 cycles with `adr` stable;
  - `rsp_dat`=0x1234_5678, `err`=0.
- `TIMEOUT_CYCLES`=8, slave never acks:
  - `stb` high exactly 8 cycles;
  - `rsp_err`=1, `rsp_dat`=0;
  - a late ack afterwards changes nothing.
- `rsp_ready` held low 5 cycles after a read:
  - `rsp_valid`/`rsp_dat` stable;
  - `cmd_ready`=0 and no new `cyc` despite `cmd_valid`=1.
- `wb_rst_i` pulsed during BUS:
  - next cycle `cyc`/`stb`=0, `rsp_valid`=0, `cmd_ready`=1;
  - the following command completes normally.
- Ack arriving in the same cycle as timeout (`TIMEOUT_CYCLES`=4, ack on the 4th `stb` cycle): `rsp_err`=0 with the read data captured.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and widths for the Wishbone host master and the benches that drive it.
package wb_pkg;

    localparam int unsigned WB_AW   = 32;
    localparam int unsigned WB_DW   = 32;
    localparam int unsigned WB_SELW = 4;

    typedef enum logic [1:0] {
        StIdle,
        StBus,
        StResp
    } wb_state_e;

    typedef struct packed {
        logic               we;
        logic [WB_AW-1:0]   adr;
        logic [WB_DW-1:0]   dat;
        logic [WB_SELW-1:0] sel;
    } wb_cmd_t;

endpackage

// File: rtl/wb_timeout_counter.sv
// Saturating cycle counter that flags when a strobe has waited TIMEOUT_CYCLES-1 cycles.
module wb_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] Limit = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Holds at the limit rather than wrapping, so expired stays asserted.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != Limit)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == Limit);

endmodule

// File: rtl/wb_host_master.sv
// Wishbone classic single-transfer master with valid/ready command and response channels.
module wb_host_master
    import wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_we,
    input  logic [WB_AW-1:0]   cmd_adr,
    input  logic [WB_DW-1:0]   cmd_dat,
    input  logic [WB_SELW-1:0] cmd_sel,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WB_DW-1:0]   rsp_dat,
    output logic               rsp_err,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic               wbm_we_o,
    output logic [WB_AW-1:0]   wbm_adr_o,
    output logic [WB_DW-1:0]   wbm_dat_o,
    output logic [WB_SELW-1:0] wbm_sel_o,
    input  logic               wbm_ack_i,
    input  logic [WB_DW-1:0]   wbm_dat_i
);

    wb_state_e        state_q, state_d;
    wb_cmd_t          cmd_q, cmd_d;
    logic [WB_DW-1:0] rsp_dat_q, rsp_dat_d;
    logic             rsp_err_q, rsp_err_d;
    logic             cmd_ready_q, cyc_q, rsp_valid_q;
    logic             cnt_clear, cnt_en, expired;

    wb_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .expired(expired)
    );

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    cmd_d     = '{we: cmd_we, adr: cmd_adr, dat: cmd_dat, sel: cmd_sel};
                    rsp_dat_d = '0;
                    rsp_err_d = 1'b0;
                    cnt_clear = 1'b1;
                    state_d   = StBus;
                end
            end
            StBus: begin
                // Ack takes priority over a timeout expiring in the same cycle.
                if (wbm_ack_i) begin
                    rsp_dat_d = cmd_q.we ? '0 : wbm_dat_i;
                    rsp_err_d = 1'b0;
                    state_d   = StResp;
                end else if (expired) begin
                    rsp_dat_d = '0;
                    rsp_err_d = 1'b1;
                    state_d   = StResp;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= StIdle;
            cmd_q       <= '0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            cmd_ready_q <= 1'b1;
            cyc_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            cmd_ready_q <= (state_d == StIdle);
            cyc_q       <= (state_d == StBus);
            rsp_valid_q <= (state_d == StResp);
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = cmd_q.we;
    assign wbm_adr_o = cmd_q.adr;
    assign wbm_dat_o = cmd_q.dat;
    assign wbm_sel_o = cmd_q.sel;

endmodule

// File: tb/tb_wb_host_master.sv
// Bench for wb_host_master: directed and random transfers on TIMEOUT_CYCLES=8 and =4 instances.
module tb_wb_host_master;

    logic        clk;
    logic        rst       [2];
    logic        cmd_valid [2];
    logic        cmd_we    [2];
    logic [31:0] cmd_adr   [2];
    logic [31:0] cmd_dat   [2];
    logic [3:0]  cmd_sel   [2];
    logic        rsp_ready [2];
    logic        ack       [2];
    logic [31:0] ack_dat   [2];
    logic        cmd_ready [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_dat   [2];
    logic        rsp_err   [2];
    logic        cyc       [2];
    logic        stb       [2];
    logic        we_o      [2];
    logic [31:0] adr_o     [2];
    logic [31:0] dat_o     [2];
    logic [3:0]  sel_o     [2];

    int checks = 0;
    int errors = 0;
    int tmo [2] = '{8, 4};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wb_host_master #(.TIMEOUT_CYCLES(8)) u_dut8 (
        .wb_clk_i(clk),          .wb_rst_i(rst[0]),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_we(cmd_we[0]),
        .cmd_adr(cmd_adr[0]),    .cmd_dat(cmd_dat[0]),     .cmd_sel(cmd_sel[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_dat(rsp_dat[0]),
        .rsp_err(rsp_err[0]),    .wbm_cyc_o(cyc[0]),       .wbm_stb_o(stb[0]),
        .wbm_we_o(we_o[0]),      .wbm_adr_o(adr_o[0]),     .wbm_dat_o(dat_o[0]),
        .wbm_sel_o(sel_o[0]),    .wbm_ack_i(ack[0]),       .wbm_dat_i(ack_dat[0])
    );

    wb_host_master #(.TIMEOUT_CYCLES(4)) u_dut4 (
        .wb_clk_i(clk),          .wb_rst_i(rst[1]),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_we(cmd_we[1]),
        .cmd_adr(cmd_adr[1]),    .cmd_dat(cmd_dat[1]),     .cmd_sel(cmd_sel[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_dat(rsp_dat[1]),
        .rsp_err(rsp_err[1]),    .wbm_cyc_o(cyc[1]),       .wbm_stb_o(stb[1]),
        .wbm_we_o(we_o[1]),      .wbm_adr_o(adr_o[1]),     .wbm_dat_o(dat_o[1]),
        .wbm_sel_o(sel_o[1]),    .wbm_ack_i(ack[1]),       .wbm_dat_i(ack_dat[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input int idx);
        check("idle_cmd_ready", 32'(cmd_ready[idx]), 32'd1);
        check("idle_cyc", 32'(cyc[idx]), 32'd0);
        check("idle_stb", 32'(stb[idx]), 32'd0);
        check("idle_rsp_valid", 32'(rsp_valid[idx]), 32'd0);
    endtask

    // One full transfer. The slave acks on stb cycle wait_n+1; reference outcome is derived
    // from whether that cycle falls within the TIMEOUT_CYCLES strobe window.
    task automatic xfer(input int idx, input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel, input int wait_n,
                        input logic [31:0] rdat, input int hold, input logic late_ack,
                        input logic push_cmd);
        int          n;
        logic        ok;
        logic        exp_err;
        logic [31:0] exp_dat;
        int          exp_stb;
        ok      = (wait_n + 1) <= tmo[idx];
        exp_err = !ok;
        exp_dat = (ok && !we) ? rdat : 32'd0;
        exp_stb = ok ? wait_n + 1 : tmo[idx];

        @(negedge clk);
        check("cmd_ready_before", 32'(cmd_ready[idx]), 32'd1);
        cmd_valid[idx] = 1'b1;
        cmd_we[idx]    = we;
        cmd_adr[idx]   = adr;
        cmd_dat[idx]   = dat;
        cmd_sel[idx]   = sel;
        @(negedge clk);
        cmd_valid[idx] = 1'b0;
        cmd_adr[idx]   = ~adr;
        cmd_dat[idx]   = ~dat;
        cmd_sel[idx]   = ~sel;
        cmd_we[idx]    = ~we;
        check("stb_after_accept", 32'(stb[idx]), 32'd1);
        n = 0;
        while (stb[idx] && n < 400) begin
            n++;
            check("bus_cyc", 32'(cyc[idx]), 32'd1);
            check("bus_adr", adr_o[idx], adr);
            check("bus_we", 32'(we_o[idx]), 32'(we));
            check("bus_sel", 32'(sel_o[idx]), 32'(sel));
            check("bus_cmd_ready", 32'(cmd_ready[idx]), 32'd0);
            check("bus_rsp_valid", 32'(rsp_valid[idx]), 32'd0);
            if (we) check("bus_dat", dat_o[idx], dat);
            ack[idx]     = (n == wait_n + 1);
            ack_dat[idx] = rdat;
            @(negedge clk);
        end
        ack[idx]     = 1'b0;
        ack_dat[idx] = $urandom;
        check("stb_cycles", 32'(n), 32'(exp_stb));
        check("rsp_valid", 32'(rsp_valid[idx]), 32'd1);
        check("rsp_err", 32'(rsp_err[idx]), 32'(exp_err));
        check("rsp_dat", rsp_dat[idx], exp_dat);
        check("rsp_cyc", 32'(cyc[idx]), 32'd0);
        for (int h = 0; h < hold; h++) begin
            ack[idx]       = late_ack;
            ack_dat[idx]   = $urandom;
            cmd_valid[idx] = push_cmd;
            rsp_ready[idx] = 1'b0;
            @(negedge clk);
            check("hold_rsp_valid", 32'(rsp_valid[idx]), 32'd1);
            check("hold_rsp_dat", rsp_dat[idx], exp_dat);
            check("hold_rsp_err", 32'(rsp_err[idx]), 32'(exp_err));
            check("hold_cmd_ready", 32'(cmd_ready[idx]), 32'd0);
            check("hold_cyc", 32'(cyc[idx]), 32'd0);
        end
        ack[idx]       = 1'b0;
        cmd_valid[idx] = 1'b0;
        rsp_ready[idx] = 1'b1;
        @(negedge clk);
        rsp_ready[idx] = 1'b0;
        check_idle_outputs(idx);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i]       = 1'b1;
            cmd_valid[i] = 1'b0;
            cmd_we[i]    = 1'b0;
            cmd_adr[i]   = '0;
            cmd_dat[i]   = '0;
            cmd_sel[i]   = '0;
            rsp_ready[i] = 1'b0;
            ack[i]       = 1'b0;
            ack_dat[i]   = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_idle_outputs(i);
            check("rst_rsp_err", 32'(rsp_err[i]), 32'd0);
            check("rst_rsp_dat", rsp_dat[i], 32'd0);
            check("rst_adr", adr_o[i], 32'd0);
            check("rst_dat", dat_o[i], 32'd0);
            check("rst_sel", 32'(sel_o[i]), 32'd0);
            check("rst_we", 32'(we_o[i]), 32'd0);
            rst[i] = 1'b0;
        end

        // Zero-wait write, 3-wait read, timeout with late ack, held response.
        xfer(0, 1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 0, 32'hAAAA_5555, 0, 1'b0, 1'b0);
        xfer(0, 1'b0, 32'h3000_0010, 32'h0, 4'hF, 3, 32'h1234_5678, 0, 1'b0, 1'b0);
        xfer(0, 1'b0, 32'h3000_0020, 32'h0, 4'h3, 1000, 32'hCAFE_F00D, 4, 1'b1, 1'b0);
        xfer(0, 1'b0, 32'h3000_0030, 32'h0, 4'hC, 2, 32'h0BAD_CAFE, 5, 1'b0, 1'b1);

        // Ack on the last allowed strobe cycle wins; one cycle later is a timeout.
        xfer(1, 1'b0, 32'h3000_0040, 32'h0, 4'hF, 3, 32'h5A5A_A5A5, 0, 1'b0, 1'b0);
        xfer(1, 1'b0, 32'h3000_0044, 32'h0, 4'hF, 4, 32'h1111_2222, 1, 1'b1, 1'b0);

        // Reset in the middle of a bus cycle.
        @(negedge clk);
        cmd_valid[0] = 1'b1;
        cmd_we[0]    = 1'b1;
        cmd_adr[0]   = 32'h3000_0050;
        cmd_dat[0]   = 32'h7777_8888;
        cmd_sel[0]   = 4'h1;
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        check("rstbus_stb", 32'(stb[0]), 32'd1);
        @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        check_idle_outputs(0);
        xfer(0, 1'b0, 32'h3000_0054, 32'h0, 4'hF, 1, 32'h9999_0000, 0, 1'b0, 1'b0);

        // Random transfers against the reference outcome.
        for (int k = 0; k < 24; k++) begin
            int idx;
            idx = int'($urandom_range(0, 1));
            xfer(idx, 1'($urandom), $urandom, $urandom, 4'($urandom), int'($urandom_range(0, 10)),
                 $urandom, int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
